// File: rtl/mem_port_arbiter.sv
// Shares one physical memory line port between the instruction-cache miss path
// and the data-cache miss/writeback path, round-robin, one transaction at a time.
module mem_port_arbiter #(
   parameter int LINE_WIDTH  = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
   typedef enum logic {SIDE_I, SIDE_D} side_t;

   state_t                state;
   side_t                 rr_last;
   logic                  i_req;
   logic                  d_req;
   logic                  grant_i;
   logic                  grant_d;
   logic [ADDR_WIDTH-1:0] i_line_addr;
   logic [ADDR_WIDTH-1:0] d_line_addr;

   // On a tie the side that did not win last time is granted.
   always_comb begin
      i_req   = i_read;
      d_req   = d_read | d_write;
      grant_d = d_req && (!i_req || rr_last == SIDE_I);
      grant_i = i_req && !grant_d;
   end

   assign i_line_addr = {i_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign d_line_addr = {d_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the wide line registers are reset too because they drive ports that must read 0 out of reset.
         state        <= IDLE;
         rr_last      <= SIDE_I;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         i_resp       <= 1'b0;
         d_resp       <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  assert (!d_read || !d_write)
                     else $warning("mem_port_arbiter: d_read and d_write both high, performing the write");
                  pmem_address <= d_line_addr;
                  pmem_wdata   <= d_wdata;
                  pmem_write   <= d_write;
                  pmem_read    <= !d_write;
                  rr_last      <= SIDE_D;
                  state        <= GRANT_D;
               end else if (grant_i) begin
                  pmem_address <= i_line_addr;
                  pmem_wdata   <= d_wdata;
                  pmem_write   <= 1'b0;
                  pmem_read    <= 1'b1;
                  rr_last      <= SIDE_I;
                  state        <= GRANT_I;
               end
            end
            GRANT_I, GRANT_D: begin
               // Strobe, address and write line stay frozen until memory answers.
               if (pmem_resp) begin
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  if (state == GRANT_I) begin
                     i_resp <= 1'b1;
                     if (pmem_read) i_rdata <= pmem_rdata;
                  end else begin
                     d_resp <= 1'b1;
                     if (pmem_read) d_rdata <= pmem_rdata;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               // One dead cycle lets a requester drop its level before the next grant.
               i_resp <= 1'b0;
               d_resp <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of arbiter and memory.
module tb_mem_port_arbiter;
   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   mem_port_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(5)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: memory contents, round-robin owner, current transaction.
   logic [LW-1:0] mem_model [logic [AW-1:0]];
   bit            busy, resp_due, pred_grant, cool, rr_d, act_d, act_write, stray_now;
   logic [AW-1:0] act_addr;
   logic [LW-1:0] act_wdata, exp_i_rdata, exp_d_rdata;
   int            cnt, mem_lat, new_pct;
   bit            lat_rand, chaos;
   bit            hist[$];

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
      return {a[AW-1:5], 5'b0};
   endfunction

   function automatic logic [LW-1:0] mem_lookup(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {8{a ^ 32'hC0DE_0000}};
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return $urandom & 32'h0000_03FF;
   endfunction

   // One clock of model + memory + requesters, evaluated at the falling edge.
   task automatic step();
      bit just_resp;
      bit dwin;
      just_resp  = 1'b0;
      pred_grant = !rst && !busy && !cool && (i_read || d_read || d_write);
      @(negedge clk);
      if (resp_due) begin
         resp_due  = 1'b0;
         busy      = 1'b0;
         just_resp = 1'b1;
         if (!act_write) begin
            if (act_d) exp_d_rdata = mem_lookup(act_addr);
            else       exp_i_rdata = mem_lookup(act_addr);
         end
         if (act_d) begin d_read = 1'b0; d_write = 1'b0; end
         else i_read = 1'b0;
      end else if (pred_grant) begin
         dwin      = (d_read || d_write) && (!i_read || !rr_d);
         busy      = 1'b1;
         cnt       = 0;
         act_d     = dwin;
         rr_d      = dwin;
         act_addr  = line_of(dwin ? d_address : i_address);
         act_write = dwin && d_write;
         act_wdata = d_wdata;
         hist.push_back(dwin);
         if (lat_rand) mem_lat = $urandom_range(1, 6);
      end

      check("i_resp", i_resp, just_resp && !act_d);
      check("d_resp", d_resp, just_resp && act_d);
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("pmem_read", pmem_read, busy && !act_write);
      check("pmem_write", pmem_write, busy && act_write);
      if (busy) begin
         check("pmem_address", pmem_address, act_addr);
         if (act_write) check("pmem_wdata", pmem_wdata, act_wdata);
      end

      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom}};
      if (stray_now) begin
         pmem_resp = 1'b1;
         stray_now = 1'b0;
      end else if (busy && !resp_due) begin
         cnt++;
         if (cnt >= mem_lat) begin
            pmem_resp = 1'b1;
            if (pmem_write) mem_model[pmem_address] = pmem_wdata;
            else            pmem_rdata = mem_lookup(pmem_address);
            resp_due = 1'b1;
         end
      end

      if (!rst) begin
         if (chaos && busy && !resp_due && $urandom_range(0, 7) == 0) begin
            if (act_d) begin d_address = rand_addr(); d_wdata = {8{$urandom}}; end
            else i_address = rand_addr();
            if ($urandom_range(0, 3) == 0) begin
               if (act_d) begin d_read = 1'b0; d_write = 1'b0; end
               else i_read = 1'b0;
            end
         end
         if (!i_read && !(busy && !act_d) && $urandom_range(0, 99) < new_pct) begin
            i_read = 1'b1; i_address = rand_addr();
         end
         if (!(d_read || d_write) && !(busy && act_d) && $urandom_range(0, 99) < new_pct) begin
            d_address = rand_addr(); d_wdata = {8{$urandom}};
            if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
         end
      end
      cool = just_resp;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);
      check("rst_pmem_address", pmem_address, 0);
      check("rst_pmem_wdata", pmem_wdata, 0);
      check("rst_i_resp", i_resp, 0);
      check("rst_d_resp", d_resp, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      busy = 1'b0; resp_due = 1'b0; cool = 1'b0; rr_d = 1'b0; cnt = 0;
      exp_i_rdata = '0; exp_d_rdata = '0; stray_now = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input string tag);
      for (int k = 0; k < 8; k++) begin
         step();
         if (busy) break;
      end
      check(tag, busy, 1);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         if (!busy && !resp_due && !(i_read || d_read || d_write)) break;
      end
      check("drain_timeout", busy || resp_due, 0);
   endtask

   initial begin
      rst = 1'b1;
      i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
      d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
      new_pct = 0; chaos = 1'b0; lat_rand = 1'b0; mem_lat = 3;
      apply_reset();

      // Single instruction read with line-offset masking.
      mem_model[32'h0000_1220] = {32{8'hAA}};
      i_read = 1'b1; i_address = 32'h0000_1234;
      wait_grant("i_grant");
      check("i_line_address", pmem_address, 32'h0000_1220);
      check("i_no_write", pmem_write, 0);
      drain(20);
      check("i_rdata_line", i_rdata, {32{8'hAA}});

      // Data writeback.
      d_write = 1'b1; d_address = 32'h8000_00FF; d_wdata = {32{8'h55}};
      wait_grant("d_grant");
      check("d_line_address", pmem_address, 32'h8000_00E0);
      check("d_wdata_line", pmem_wdata, {32{8'h55}});
      check("d_is_write", pmem_write, 1);
      drain(20);
      check("d_rdata_unchanged", d_rdata, 0);

      // Simultaneous and persistent requests after reset: D first, then alternate.
      apply_reset();
      lat_rand = 1'b1;
      hist.delete();
      i_read = 1'b1; i_address = rand_addr();
      d_read = 1'b1; d_address = rand_addr();
      new_pct = 100;
      for (int k = 0; k < 60; k++) step();
      new_pct = 0;
      drain(40);
      check("rr_count", hist.size() >= 4, 1);
      if (hist.size() >= 4) begin
         check("rr_first_d", hist[0], 1);
         check("rr_then_i", hist[1], 0);
         check("rr_then_d", hist[2], 1);
         check("rr_then_i2", hist[3], 0);
      end

      // Reset one cycle into a grant.
      lat_rand = 1'b0; mem_lat = 10;
      i_read = 1'b1; i_address = rand_addr();
      wait_grant("mid_grant");
      check("mid_grant_strobe", pmem_read, 1);
      apply_reset();
      for (int k = 0; k < 4; k++) step();
      check("post_rst_address", pmem_address, 0);

      // Illegal read+write (write wins), then a stray memory response while idle.
      mem_lat = 2;
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0340; d_wdata = {8{32'h1357_9BDF}};
      wait_grant("illegal_grant");
      check("illegal_is_write", pmem_write, 1);
      drain(20);
      check("illegal_stored", mem_lookup(32'h0000_0340), {8{32'h1357_9BDF}});
      step();
      stray_now = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Random traffic with protocol violations on the active requester.
      new_pct = 35; chaos = 1'b1; lat_rand = 1'b1;
      for (int k = 0; k < 1500; k++) step();
      new_pct = 0; chaos = 1'b0;
      drain(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
